// File: rtl/tdm_partition_sched.sv
// Time-division scheduler: rotates ownership of one shared output among
// NPART partitions. Each owned slot lasts SLOT_LEN cycles and is followed by
// FLUSH_LEN scrub cycles in which nothing is driven. Every partition keeps a
// private 3-state sub-FSM that only advances while it owns the output.
module tdm_partition_sched #(
    parameter int WIDTH     = 16,
    parameter int NPART     = 4,
    parameter int SLOT_LEN  = 10,
    parameter int FLUSH_LEN = 1,
    localparam int PW       = $clog2(NPART)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NPART-1:0]       part_mask,
    input  logic [NPART*WIDTH-1:0] data,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    output logic [PW-1:0]          cur_part,
    output logic                   in_flush,
    output logic [1:0]             sub_state
);

    localparam int MAX_LEN = (SLOT_LEN > FLUSH_LEN) ? SLOT_LEN : FLUSH_LEN;
    localparam int TW      = $clog2(MAX_LEN);

    localparam logic [TW-1:0] SLOT_LAST  = TW'(SLOT_LEN - 1);
    localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_LEN - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    localparam logic [1:0] SUB_IDLE = 2'd0;
    localparam logic [1:0] SUB_RUN  = 2'd1;
    localparam logic [1:0] SUB_HOLD = 2'd2;

    typedef enum logic {
        G_FLUSH = 1'b0,
        G_SLOT  = 1'b1
    } gstate_t;

    // Registered state
    gstate_t          state_q;
    logic [TW-1:0]    timer_q;
    logic [PW-1:0]    part_q;
    logic             fresh_q;       // first selection after reset: search from index 0
    logic [1:0]       sub_q [NPART];
    logic [WIDTH-1:0] out_q;
    logic             valid_q;

    // Next-state values
    gstate_t          state_d;
    logic [TW-1:0]    timer_d;
    logic [PW-1:0]    part_d;
    logic             fresh_d;
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic             sub_we;
    logic [1:0]       own_sub;
    logic [1:0]       own_sub_nxt;
    logic [WIDTH-1:0] own_data;
    logic             own_active;

    // Owner search result
    logic             pick_found;
    logic [PW-1:0]    pick_idx;

    // Round-robin search for the next eligible partition. Normally it starts
    // just after the current owner (wrapping, so the owner itself is the last
    // candidate); straight out of reset it starts at index 0 inclusive.
    function automatic logic [PW:0] pick_next(
        input logic [NPART-1:0] mask,
        input logic [PW-1:0]    cur,
        input logic             fresh
    );
        logic [PW:0] result;
        int          cand;
        result = '0;
        for (int k = NPART - 1; k >= 0; k--) begin
            cand = fresh ? k : (int'(cur) + 1 + k) % NPART;
            // iterate backwards so the lowest k (earliest candidate) wins
            if (mask[cand]) begin
                result = {1'b1, PW'(cand)};
            end
        end
        return result;
    endfunction

    // Decide the next owner from the live mask; only consumed at flush end
    always_comb begin
        {pick_found, pick_idx} = pick_next(part_mask, part_q, fresh_q);
    end

    // Owner's sub-FSM transition, computed from its own data only
    always_comb begin
        own_data   = data[int'(part_q)*WIDTH +: WIDTH];
        own_sub    = sub_q[part_q];
        own_active = (own_data != '0);
        unique case (own_sub)
            SUB_IDLE: own_sub_nxt = own_active ? SUB_RUN : SUB_IDLE;
            SUB_RUN:  own_sub_nxt = own_active ? SUB_RUN : SUB_HOLD;
            SUB_HOLD: own_sub_nxt = own_active ? SUB_RUN : SUB_IDLE;
            default:  own_sub_nxt = SUB_IDLE;   // illegal encoding recovers to IDLE
        endcase
    end

    // Global FLUSH/SLOT sequencing, timer and registered output selection
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        timer_d = timer_q;
        part_d  = part_q;
        fresh_d = fresh_q;
        out_d   = '0;
        valid_d = 1'b0;
        sub_we  = 1'b0;

        if (en) begin
            unique case (state_q)
                G_FLUSH: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIMER_ONE;
                    end else if (pick_found) begin
                        part_d  = pick_idx;
                        state_d = G_SLOT;
                        timer_d = SLOT_LAST;
                        fresh_d = 1'b0;
                    end else begin
                        timer_d = FLUSH_LAST;   // nobody eligible: scrub again
                    end
                end
                G_SLOT: begin
                    sub_we = 1'b1;
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIMER_ONE;
                        if (own_sub_nxt == SUB_RUN) begin
                            out_d   = own_data;
                            valid_d = 1'b1;
                        end
                    end else begin
                        // last slot edge: sub-FSM step still commits, output cleared
                        state_d = G_FLUSH;
                        timer_d = FLUSH_LAST;
                    end
                end
                default: begin
                    state_d = G_FLUSH;
                    timer_d = FLUSH_LAST;
                end
            endcase
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= G_FLUSH;
            timer_q <= FLUSH_LAST;
            part_q  <= '0;
            fresh_q <= 1'b1;
            out_q   <= '0;
            valid_q <= 1'b0;
            // NOTE: the sub-state array is small and must not leak across a
            // reset, so every entry is cleared rather than left unreset.
            for (int p = 0; p < NPART; p++) begin
                sub_q[p] <= SUB_IDLE;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of statement order.
            state_q <= state_d;
            timer_q <= timer_d;
            part_q  <= part_d;
            fresh_q <= fresh_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            if (sub_we) begin
                sub_q[part_q] <= own_sub_nxt;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign cur_part  = part_q;
    assign in_flush  = (state_q == G_FLUSH);
    assign sub_state = sub_q[part_q];

endmodule
